// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory handshake, DECODE-facing instruction and PC,
// and the commit-time next-PC controls coming back from the datapath.
interface fetch_if #(
  parameter int W_CPU = 32
);
  logic             imem_req;
  logic [W_CPU-1:0] imem_addr;
  logic             imem_ack;
  logic [W_CPU-1:0] imem_rdata;
  logic [W_CPU-1:0] inst;
  logic             inst_valid;
  logic [W_CPU-1:0] pc;
  logic [W_CPU-1:0] pc_plus4;
  logic             commit;
  logic [1:0]       pc_src;
  logic             jump_reg;
  logic [25:0]      jaddr;
  logic [15:0]      imm;
  logic             br_taken;
  logic [W_CPU-1:0] rs_data;
  logic             halt;
  logic             halted;
  logic             align_err;

  modport master (
    output imem_req, imem_addr, inst, inst_valid, pc, pc_plus4, halted, align_err,
    input  imem_ack, imem_rdata, commit, pc_src, jump_reg, jaddr, imm, br_taken, rs_data, halt
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_valid, pc, pc_plus4, halted, align_err,
    output imem_ack, imem_rdata, commit, pc_src, jump_reg, jaddr, imm, br_taken, rs_data, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches one word per instruction over req/ack and
// holds it for DECODE until commit, then advances the PC from pc_src / branch / jump operands.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | just out of reset, fetch starts next cycle
// S_REQ    | imem_req high at pc, waiting for imem_ack
// S_VALID  | inst held for DECODE, waiting for commit
// S_HALTED | BREAK retired, fetch stopped until reset
module fetch_unit #(
  parameter int               W_CPU    = 32,
  parameter logic [W_CPU-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  localparam logic [1:0] PC_SRC_NEXT = 2'd0;
  localparam logic [1:0] PC_SRC_JUMP = 2'd1;
  localparam logic [1:0] PC_SRC_BRCH = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_HALTED} state_t;

  state_t           state_q, state_d;
  logic [W_CPU-1:0] pc_q, pc_d;
  logic [W_CPU-1:0] inst_q, inst_d;
  logic             align_err_q, align_err_d;

  logic [W_CPU-1:0] pc_plus4;
  logic [W_CPU-1:0] br_off;
  logic [W_CPU-1:0] j_target;
  logic [W_CPU-1:0] jr_target;
  logic [W_CPU-1:0] next_pc;
  logic             jr_misaligned;

  assign pc_plus4      = pc_q + W_CPU'(4);
  assign br_off        = {{(W_CPU-18){bus.imm[15]}}, bus.imm, 2'b00};
  assign j_target      = {pc_plus4[W_CPU-1:28], bus.jaddr, 2'b00};
  assign jr_target     = {bus.rs_data[W_CPU-1:2], 2'b00};
  assign jr_misaligned = |bus.rs_data[1:0];

  // Unknown pc_src encodings fall through to sequential fetch.
  always_comb begin
    next_pc = pc_plus4;
    case (bus.pc_src)
      PC_SRC_NEXT: next_pc = pc_plus4;
      PC_SRC_BRCH: if (bus.br_taken) next_pc = pc_plus4 + br_off;
      PC_SRC_JUMP: next_pc = bus.jump_reg ? jr_target : j_target;
      default:     next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    align_err_d = align_err_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (bus.imem_ack) begin
          inst_d  = bus.imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (bus.commit) begin
          pc_d = next_pc;
          if (bus.pc_src == PC_SRC_JUMP && bus.jump_reg && jr_misaligned)
            align_err_d = 1'b1;
          state_d = bus.halt ? S_HALTED : S_REQ;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      align_err_q <= align_err_d;
    end
  end

  assign bus.imem_req   = (state_q == S_REQ);
  assign bus.imem_addr  = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = (state_q == S_VALID);
  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.halted     = (state_q == S_HALTED);
  assign bus.align_err  = align_err_q;

endmodule
